rice_pkt_ctrl: RTL and testbench

Packet sequencer between the 32-bit telemetry word stream (`data`/`datavalid`) and the Rice decoder. Hunts for the frame sync word, parses the packet header, and forwards exactly the declared number of payload words to the decoder through a 4-entry buffer with a valid/ready handshake. Reports the per-packet decode parameters, completion, and errors. It sits directly upstream of the packet word register feeding the decoder.

---
 rtl/rice_pkt_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_rice_pkt_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rice_pkt_ctrl.sv
// Packet sequencer: sync hunt, header parse, N-word payload forwarding via a 4-entry buffer.
// Optional trailing XOR checksum word enabled by defining RICE_PKT_CKSUM_EN.
module rice_pkt_ctrl #(
  parameter logic [31:0] SYNC_WORD = 32'h1ACFFC1D,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic        datavalid,
  input  logic        dec_ready,
  output logic [31:0] pdata,
  output logic        pvalid,
  output logic [3:0]  k_param,
  output logic [15:0] nsamples,
  output logic        hdr_valid,
  output logic        pkt_done,
  output logic        pkt_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam logic [2:0] ST_HUNT    = 3'd0;
  localparam logic [2:0] ST_HEADER  = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
`ifdef RICE_PKT_CKSUM_EN
  localparam logic [2:0] ST_CHECK   = 3'd3;
`endif
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  localparam logic [1:0] ERR_HDR  = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_TOUT = 2'd2;
`ifdef RICE_PKT_CKSUM_EN
  localparam logic [1:0] ERR_CSUM = 2'd3;
`endif

  logic [2:0]    state_q, state_d;
  logic [3:0]    k_q, k_d;
  logic [15:0]   ns_q, ns_d;
  logic [7:0]    nw_q, nw_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          hdr_q, hdr_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    ecode_q, ecode_d;
`ifdef RICE_PKT_CKSUM_EN
  logic [31:0]   xor_q, xor_d;
`endif

  logic [31:0]   mem_q [4];
  logic [1:0]    wp_q, wp_d;
  logic [1:0]    rp_q, rp_d;
  logic [2:0]    occ_q, occ_d;

  logic          push;
  logic          pop;
  logic          flush;
  logic          err_hit;
  logic [1:0]    err_sel;

  assign pop = (occ_q != 3'd0) && dec_ready;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ns_d    = ns_q;
    nw_d    = nw_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    hdr_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ecode_d = ecode_q;
`ifdef RICE_PKT_CKSUM_EN
    xor_d   = xor_q;
`endif
    push    = 1'b0;
    err_hit = 1'b0;
    err_sel = ERR_HDR;

    case (state_q)
      ST_HUNT: begin
        idle_d = '0;
        if (datavalid && (data == SYNC_WORD)) begin
          state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (datavalid) begin
          if ((data[23:16] == 8'd0) || (data[27:24] != 4'd0)) begin
            err_hit = 1'b1;
            err_sel = ERR_HDR;
          end else begin
            k_d     = data[31:28];
            nw_d    = data[23:16];
            ns_d    = data[15:0];
            cnt_d   = '0;
            hdr_d   = 1'b1;
`ifdef RICE_PKT_CKSUM_EN
            xor_d   = '0;
`endif
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (datavalid) begin
          push  = 1'b1;
          cnt_d = cnt_q + 8'd1;
`ifdef RICE_PKT_CKSUM_EN
          xor_d = xor_q ^ data;
          if (cnt_d == nw_q) state_d = ST_CHECK;
`else
          if (cnt_d == nw_q) state_d = ST_DRAIN;
`endif
        end
      end
`ifdef RICE_PKT_CKSUM_EN
      ST_CHECK: begin
        if (datavalid) begin
          if (data != xor_q) begin
            err_hit = 1'b1;
            err_sel = ERR_CSUM;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
`endif
      ST_DRAIN: begin
        idle_d = '0;
        // Finish in the cycle that empties the buffer so pkt_done follows the last pop directly.
        if ((occ_q == 3'd0) || ((occ_q == 3'd1) && pop)) begin
          done_d  = 1'b1;
          state_d = ST_HUNT;
        end
      end
      default: state_d = ST_HUNT;
    endcase

    if ((state_q != ST_HUNT) && (state_q != ST_DRAIN)) begin
      if (datavalid) begin
        idle_d = '0;
      end else if (idle_q == IDLE_LAST) begin
        err_hit = 1'b1;
        err_sel = ERR_TOUT;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end

    if (push && (occ_q == 3'd4) && !pop) begin
      err_hit = 1'b1;
      err_sel = ERR_OVF;
    end

    flush = err_hit;
    if (err_hit) begin
      err_d   = 1'b1;
      ecode_d = err_sel;
      state_d = ST_HUNT;
      idle_d  = '0;
      cnt_d   = '0;
    end
  end

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    occ_d = occ_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      occ_d = '0;
    end else begin
      if (push) wp_d = wp_q + 2'd1;
      if (pop)  rp_d = rp_q + 2'd1;
      occ_d = occ_q + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_HUNT;
      k_q     <= '0;
      ns_q    <= '0;
      nw_q    <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      hdr_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ecode_q <= '0;
`ifdef RICE_PKT_CKSUM_EN
      xor_q   <= '0;
`endif
      wp_q    <= '0;
      rp_q    <= '0;
      occ_q   <= '0;
      for (int unsigned i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ns_q    <= ns_d;
      nw_q    <= nw_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      hdr_q   <= hdr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ecode_q <= ecode_d;
`ifdef RICE_PKT_CKSUM_EN
      xor_q   <= xor_d;
`endif
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      occ_q   <= occ_d;
      if (push && !flush) mem_q[wp_q] <= data;
    end
  end

  assign pdata     = mem_q[rp_q];
  assign pvalid    = (occ_q != 3'd0);
  assign k_param   = k_q;
  assign nsamples  = ns_q;
  assign hdr_valid = hdr_q;
  assign pkt_done  = done_q;
  assign pkt_err   = err_q;
  assign err_code  = ecode_q;
  assign busy      = (state_q != ST_HUNT);

endmodule

// File: tb/tb_rice_pkt_ctrl.sv
// Directed self-checking bench for rice_pkt_ctrl; checksum cases run when RICE_PKT_CKSUM_EN is defined.
module tb_rice_pkt_ctrl;

  localparam logic [31:0] SYNC = 32'h1ACFFC1D;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data;
  logic        datavalid;
  logic        dec_ready;
  logic [31:0] pdata;
  logic        pvalid;
  logic [3:0]  k_param;
  logic [15:0] nsamples;
  logic        hdr_valid;
  logic        pkt_done;
  logic        pkt_err;
  logic [1:0]  err_code;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  rice_pkt_ctrl #(.SYNC_WORD(SYNC), .TIMEOUT(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .datavalid (datavalid),
    .dec_ready (dec_ready),
    .pdata     (pdata),
    .pvalid    (pvalid),
    .k_param   (k_param),
    .nsamples  (nsamples),
    .hdr_valid (hdr_valid),
    .pkt_done  (pkt_done),
    .pkt_err   (pkt_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    data      = w;
    datavalid = 1'b1;
    tick();
    datavalid = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    data      = '0;
    datavalid = 1'b0;
    dec_ready = 1'b1;
    #12;
    check("rst_pvalid", 32'(pvalid), 32'd0);
    check("rst_pdata", pdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_k", 32'(k_param), 32'd0);
    check("rst_ns", 32'(nsamples), 32'd0);
    check("rst_flags", {29'd0, hdr_valid, pkt_done, pkt_err}, 32'd0);
    check("rst_ecode", 32'(err_code), 32'd0);
    reset = 1'b1;
    tick();

    // basic packet, N=3
    send(SYNC);
    check("t1_busy", 32'(busy), 32'd1);
    send(32'h5003_0010);
    check("t1_hdr", 32'(hdr_valid), 32'd1);
    check("t1_k", 32'(k_param), 32'd5);
    check("t1_ns", 32'(nsamples), 32'd16);
    send(32'd1);
    check("t1_hdr_pulse", 32'(hdr_valid), 32'd0);
    check("t1_w1", {pvalid, pdata[30:0]}, {1'b1, 31'd1});
    send(32'd2);
    check("t1_w2", {pvalid, pdata[30:0]}, {1'b1, 31'd2});
    send(32'd3);
    check("t1_w3", {pvalid, pdata[30:0]}, {1'b1, 31'd3});
    check("t1_nodone", 32'(pkt_done), 32'd0);
    tick();
    check("t1_done", 32'(pkt_done), 32'd1);
    check("t1_busy_off", 32'(busy), 32'd0);
    check("t1_empty", 32'(pvalid), 32'd0);
    tick();
    check("t1_done_pulse", 32'(pkt_done), 32'd0);

    // header without sync
    send(32'hDEAD_BEEF);
    send(32'h1234_5678);
    send(32'h5003_0010);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_hdr", 32'(hdr_valid), 32'd0);
    send(32'd9);
    check("t2_pvalid", 32'(pvalid), 32'd0);

    // N=0 header error, then a good packet
    send(SYNC);
    send(32'h5000_0010);
    check("t3_err", 32'(pkt_err), 32'd1);
    check("t3_ecode", 32'(err_code), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_hdr", 32'(hdr_valid), 32'd0);
    send(SYNC);
    check("t3_err_pulse", 32'(pkt_err), 32'd0);
    send(32'h3001_0007);
    check("t3_hdr2", 32'(hdr_valid), 32'd1);
    check("t3_k", 32'(k_param), 32'd3);
    check("t3_ns", 32'(nsamples), 32'd7);
    send(32'h0000_A5A5);
    check("t3_pdata", pdata, 32'h0000_A5A5);
    tick();
    check("t3_done", 32'(pkt_done), 32'd1);

    // overflow: decoder stalled, fifth push
    dec_ready = 1'b0;
    send(SYNC);
    send(32'h0006_0000);
    for (int i = 1; i <= 4; i++) send(32'h100 + 32'(i));
    check("t4_full_head", {pvalid, pdata[30:0]}, {1'b1, 31'h101});
    check("t4_noerr", 32'(pkt_err), 32'd0);
    send(32'h105);
    check("t4_err", 32'(pkt_err), 32'd1);
    check("t4_ecode", 32'(err_code), 32'd1);
    check("t4_flush", 32'(pvalid), 32'd0);
    send(32'h106);
    check("t4_hunt", {30'd0, busy, pvalid}, 32'd0);

    // push and pop together while full is legal
    send(SYNC);
    send(32'h0005_0000);
    for (int i = 1; i <= 4; i++) send(32'h200 + 32'(i));
    check("t5_head", pdata, 32'h201);
    dec_ready = 1'b1;
    send(32'h205);
    check("t5_noerr", 32'(pkt_err), 32'd0);
    check("t5_head2", pdata, 32'h202);
    for (int i = 3; i <= 5; i++) begin
      tick();
      check("t5_drain", pdata, 32'h200 + 32'(i));
    end
    check("t5_notdone", 32'(pkt_done), 32'd0);
    tick();
    check("t5_done", 32'(pkt_done), 32'd1);
    check("t5_err_none", 32'(pkt_err), 32'd0);

    // reserved bits nonzero
    send(SYNC);
    send(32'h5103_0010);
    check("t6_err", 32'(pkt_err), 32'd1);
    check("t6_ecode", 32'(err_code), 32'd0);

    // timeout after 64 idle cycles
    send(SYNC);
    send(32'h1003_0020);
    send(32'h77);
    check("t7_word", pdata, 32'h77);
    for (int i = 0; i < 63; i++) tick();
    check("t7_pre_err", 32'(pkt_err), 32'd0);
    check("t7_pre_busy", 32'(busy), 32'd1);
    tick();
    check("t7_err", 32'(pkt_err), 32'd1);
    check("t7_ecode", 32'(err_code), 32'd2);
    check("t7_busy", 32'(busy), 32'd0);

    // reset mid-packet
    dec_ready = 1'b0;
    send(SYNC);
    send(32'h7002_0009);
    send(32'h11);
    check("t8_pre", {30'd0, busy, pvalid}, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("t8_clear", {28'd0, busy, pvalid, hdr_valid, pkt_err}, 32'd0);
    check("t8_k", 32'(k_param), 32'd0);
    check("t8_ecode", 32'(err_code), 32'd0);
    tick();
    check("t8_quiet", {30'd0, pkt_done, pkt_err}, 32'd0);
    reset = 1'b1;
    dec_ready = 1'b1;
    tick();

`ifdef RICE_PKT_CKSUM_EN
    send(SYNC);
    send(32'h0002_0004);
    send(32'hF0);
    send(32'h0F);
    send(32'hFF);
    check("c1_noerr", 32'(pkt_err), 32'd0);
    tick();
    check("c1_done", 32'(pkt_done), 32'd1);
    send(SYNC);
    send(32'h0002_0004);
    send(32'hF0);
    send(32'h0F);
    send(32'hFE);
    check("c2_err", 32'(pkt_err), 32'd1);
    check("c2_ecode", 32'(err_code), 32'd3);
    tick();
    check("c2_nodone", 32'(pkt_done), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
